// File: rtl/stream_checker_pkg.sv
// rtl/stream_checker_pkg.sv - shared types and masked-compare helper for the stream vector checker
package stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers zero-extend their words to this width; zero bits in the mask never fail.
  localparam int MAX_DATA_WIDTH = 256;

  function automatic logic masked_fail(
    input logic [MAX_DATA_WIDTH-1:0] act_w,
    input logic [MAX_DATA_WIDTH-1:0] exp_w,
    input logic [MAX_DATA_WIDTH-1:0] msk_w
  );
    return |((act_w ^ exp_w) & msk_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stream_vector_checker.sv
// rtl/stream_vector_checker.sv - masked compare of a sample stream with per-run statistics and pass/fail
module stream_vector_checker
  import stream_checker_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int VECTOR_SIZE = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] actual,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic [DATA_WIDTH-1:0] mask,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [CNT_WIDTH-1:0]  first_err_index,
  output logic                  first_err_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  test_passed
);

  localparam logic [CNT_WIDTH-1:0] LAST_INDEX = CNT_WIDTH'(VECTOR_SIZE - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] sample_count_q, sample_count_d;
  logic [CNT_WIDTH-1:0] first_err_index_q, first_err_index_d;
  logic                 first_err_valid_q, first_err_valid_d;
  logic                 mismatch_q, mismatch_d;
  logic                 test_passed_q, test_passed_d;

  logic accept;
  logic sample_fail;

  // start takes priority: a sample presented alongside it is dropped.
  assign accept      = (state_q == RUN) && !start && sample_valid;
  assign sample_fail = accept && masked_fail(MAX_DATA_WIDTH'(actual),
                                             MAX_DATA_WIDTH'(expected),
                                             MAX_DATA_WIDTH'(mask));

  always_comb begin
    state_d           = state_q;
    sample_count_d    = sample_count_q;
    first_err_index_d = first_err_index_q;
    first_err_valid_d = first_err_valid_q;
    mismatch_d        = sample_fail;
    test_passed_d     = test_passed_q;

    if (start) begin
      state_d           = RUN;
      sample_count_d    = '0;
      first_err_index_d = '0;
      first_err_valid_d = 1'b0;
      test_passed_d     = 1'b1;
    end else if (accept) begin
      sample_count_d = sample_count_q + CNT_WIDTH'(1);
      if (sample_count_q == LAST_INDEX) begin
        state_d = DONE;
      end
      if (sample_fail) begin
        test_passed_d = 1'b0;
        if (!first_err_valid_q) begin
          first_err_index_d = sample_count_q;
          first_err_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      sample_count_q    <= '0;
      first_err_index_q <= '0;
      first_err_valid_q <= 1'b0;
      mismatch_q        <= 1'b0;
      test_passed_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      sample_count_q    <= sample_count_d;
      first_err_index_q <= first_err_index_d;
      first_err_valid_q <= first_err_valid_d;
      mismatch_q        <= mismatch_d;
      test_passed_q     <= test_passed_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_error_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .inc   (sample_fail),
    .count (error_count)
  );

  assign mismatch        = mismatch_q;
  assign sample_count    = sample_count_q;
  assign first_err_index = first_err_index_q;
  assign first_err_valid = first_err_valid_q;
  assign test_passed     = test_passed_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_stream_vector_checker.sv
// tb/tb_stream_vector_checker.sv - randomized and directed checks of stream_vector_checker against a run-log model
module tb_stream_vector_checker;

  localparam int VS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sample_valid;
  logic [15:0] actual, expected, mask;
  logic        mismatch, first_err_valid, busy, done, test_passed;
  logic [31:0] error_count, sample_count, first_err_index;

  logic        s_start, s_valid;
  logic [15:0] s_act, s_exp, s_mask;
  logic        s_mismatch, s_first_err_valid, s_busy, s_done, s_test_passed;
  logic [1:0]  s_error_count, s_sample_count, s_first_err_index;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_vector_checker #(.DATA_WIDTH(16), .CNT_WIDTH(32), .VECTOR_SIZE(VS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .actual(actual), .expected(expected), .mask(mask),
    .mismatch(mismatch), .error_count(error_count), .sample_count(sample_count),
    .first_err_index(first_err_index), .first_err_valid(first_err_valid),
    .busy(busy), .done(done), .test_passed(test_passed)
  );

  stream_vector_checker #(.DATA_WIDTH(16), .CNT_WIDTH(2), .VECTOR_SIZE(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sample_valid(s_valid),
    .actual(s_act), .expected(s_exp), .mask(s_mask),
    .mismatch(s_mismatch), .error_count(s_error_count), .sample_count(s_sample_count),
    .first_err_index(s_first_err_index), .first_err_valid(s_first_err_valid),
    .busy(s_busy), .done(s_done), .test_passed(s_test_passed)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Model: the log of pass/fail results of every sample accepted in the current run.
  bit m_started;
  bit m_res[$];
  bit m_mis;

  function automatic int m_errs();
    int n = 0;
    foreach (m_res[i]) n += int'(m_res[i]);
    return n;
  endfunction

  function automatic int m_first();
    foreach (m_res[i]) if (m_res[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0;
      m_res.delete();
      m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (start) begin
        m_started = 1'b1;
        m_res.delete();
      end else if (m_started && m_res.size() < VS && sample_valid) begin
        m_mis = (((actual ^ expected) & mask) != 16'h0);
        m_res.push_back(m_mis);
      end
    end
  end

  always @(negedge clk) begin
    int fi;
    if (rst_n) begin
      fi = m_first();
      check("mismatch", 64'(mismatch), 64'(m_mis));
      check("sample_count", 64'(sample_count), 64'(m_res.size()));
      check("error_count", 64'(error_count), 64'(m_errs()));
      check("first_err_valid", 64'(first_err_valid), 64'(fi >= 0));
      check("first_err_index", 64'(first_err_index), 64'(fi >= 0 ? fi : 0));
      check("busy", 64'(busy), 64'(m_started && m_res.size() < VS));
      check("done", 64'(done), 64'(m_started && m_res.size() == VS));
      check("test_passed", 64'(test_passed), 64'(m_started && m_errs() == 0));
    end
  end

  task automatic cycle(input logic st, input logic v, input logic [15:0] a,
                       input logic [15:0] e, input logic [15:0] m);
    start = st; sample_valid = v; actual = a; expected = e; mask = m;
    @(posedge clk);
    #1;
    start = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    check("areset_sample_count", 64'(sample_count), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_test_passed", 64'(test_passed), 64'd0);
    check("areset_error_count", 64'(error_count), 64'd0);
    check("areset_small_sample_count", 64'(s_sample_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; sample_valid = 1'b0; actual = '0; expected = '0; mask = '0;
    s_start = 1'b0; s_valid = 1'b0; s_act = '0; s_exp = '0; s_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_test_passed", 64'(test_passed), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Samples in IDLE are ignored.
    repeat (2) cycle(1'b0, 1'b1, 16'h0001, 16'h0002, 16'hFFFF);
    check("idle_sample_count", 64'(sample_count), 64'd0);

    // Clean run.
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < VS; k++) cycle(1'b0, 1'b1, 16'(k), 16'(k), 16'hFFFF);
    check("clean_done", 64'(done), 64'd1);
    check("clean_errors", 64'(error_count), 64'd0);
    check("clean_passed", 64'(test_passed), 64'd1);
    check("clean_first_valid", 64'(first_err_valid), 64'd0);

    // Samples in DONE are ignored.
    repeat (2) cycle(1'b0, 1'b1, 16'h0001, 16'h0000, 16'hFFFF);
    check("done_sample_count", 64'(sample_count), 64'd8);
    check("done_errors", 64'(error_count), 64'd0);

    // Samples 2 and 5 fail.
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < VS; k++) begin
      if (k == 2 || k == 5) cycle(1'b0, 1'b1, 16'h00FF, 16'h00FE, 16'hFFFF);
      else                  cycle(1'b0, 1'b1, 16'h00FF, 16'h00FF, 16'hFFFF);
      if (k == 2) check("pulse_after_2", 64'(mismatch), 64'd1);
      if (k == 3) check("no_pulse_after_3", 64'(mismatch), 64'd0);
    end
    check("two_err_count", 64'(error_count), 64'd2);
    check("two_err_first", 64'(first_err_index), 64'd2);
    check("two_err_passed", 64'(test_passed), 64'd0);

    // Differing bit is masked out.
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    repeat (VS) cycle(1'b0, 1'b1, 16'h1234, 16'h1235, 16'hFFFE);
    check("masked_errors", 64'(error_count), 64'd0);
    check("masked_passed", 64'(test_passed), 64'd1);

    // start together with a failing sample mid-run.
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0001, 16'h0001, 16'hFFFF);
    cycle(1'b0, 1'b1, 16'h0001, 16'h0003, 16'hFFFF);
    cycle(1'b1, 1'b1, 16'h00FF, 16'h00FE, 16'hFFFF);
    check("restart_sample_count", 64'(sample_count), 64'd0);
    check("restart_errors", 64'(error_count), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_passed", 64'(test_passed), 64'd1);
    check("restart_mismatch", 64'(mismatch), 64'd0);

    // Small instance: every sample fails.
    s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_act = 16'hAAAA; s_exp = 16'h5555; s_mask = 16'hFFFF;
      @(posedge clk); #1 s_valid = 1'b0;
    end
    check("small_errors", 64'(s_error_count), 64'd3);
    check("small_done", 64'(s_done), 64'd1);
    check("small_first", 64'(s_first_err_index), 64'd0);
    check("small_passed", 64'(s_test_passed), 64'd0);

    // Reset mid-run.
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    repeat (3) cycle(1'b0, 1'b1, 16'h0001, 16'h0002, 16'hFFFF);
    async_reset_check();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        st, v;
      logic [15:0] e, a, m;
      st = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      e  = 16'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? (e ^ (16'h1 << $urandom_range(0, 15))) : e;
      case ($urandom_range(0, 2))
        0:       m = 16'hFFFF;
        1:       m = 16'h0000;
        default: m = 16'($urandom);
      endcase
      cycle(st, v, a, e, m);
      if (i == 700) async_reset_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
